// File: rtl/trace_pkg.sv
// trace_pkg: retire record layout and output sequencer states shared by the trace path
package trace_pkg;
  localparam int REC_W = 168;
  localparam int PC_MSB = 167, PC_LSB = 136;
  localparam int INSTR_MSB = 135, INSTR_LSB = 104;
  localparam int RADDR_MSB = 103, RADDR_LSB = 99;
  localparam int RDATA_MSB = 98, RDATA_LSB = 67;
  localparam int LOAD_BIT = 66, STORE_BIT = 65, FLOAT_BIT = 64;
  localparam int MADDR_MSB = 63, MADDR_LSB = 32;
  localparam int MDATA_MSB = 31, MDATA_LSB = 0;
  typedef enum logic [1:0] {IDLE, SETUP, PULSE} state_e;
endpackage

// File: rtl/trace_fifo.sv
// trace_fifo: synchronous FIFO; pointers carry one extra wrap bit to tell full from empty
module trace_fifo #(
  parameter int DEPTH = 4,
  parameter int REC_W = trace_pkg::REC_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [REC_W-1:0] wdata_i,
  output logic [REC_W-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, rd_q;
  assign empty_o = wr_q == rd_q;
  assign full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign rdata_o = mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i) rd_q <= rd_q + 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/trace_arbiter.sv
// trace_arbiter: round-robin merge of two retire ports into a paced, edge-separated tracer stream
module trace_arbiter import trace_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             trace_en_i,
  input  logic             a_valid_i,
  output logic             a_ready_o,
  input  logic [REC_W-1:0] a_rec_i,
  input  logic             b_valid_i,
  output logic             b_ready_o,
  input  logic [REC_W-1:0] b_rec_i,
  output logic             valid_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      instr_o,
  output logic [31:0]      reg_data_o,
  output logic [31:0]      mem_addr_o,
  output logic [31:0]      mem_data_o,
  output logic [4:0]       reg_addr_o,
  output logic             is_load_o,
  output logic             is_store_o,
  output logic             is_float_o,
  output logic [31:0]      emit_cnt_o
);
  state_e state_q, state_d;
  logic rr_q, rr_d;
  logic [REC_W-1:0] rec_q, rec_d, rdata;
  logic [31:0] cnt_q, cnt_d;
  logic full, empty, grant_a, grant_b, a_xfer, b_xfer, push, pop;
  assign grant_a = a_valid_i && (!b_valid_i || !rr_q);
  assign grant_b = b_valid_i && (!a_valid_i || rr_q);
  // With tracing off a granted record is swallowed, so fullness must not stall it
  assign a_ready_o = grant_a && (!full || !trace_en_i);
  assign b_ready_o = grant_b && (!full || !trace_en_i);
  assign a_xfer = a_valid_i && a_ready_o;
  assign b_xfer = b_valid_i && b_ready_o;
  assign push = (a_xfer || b_xfer) && trace_en_i;
  assign pop = !empty && (state_q != SETUP);
  trace_fifo #(.DEPTH(DEPTH), .REC_W(REC_W)) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (a_xfer ? a_rec_i : b_rec_i),
    .rdata_o (rdata),
    .full_o  (full),
    .empty_o (empty)
  );
  always_comb begin
    rr_d = a_xfer ? 1'b1 : b_xfer ? 1'b0 : rr_q;
    rec_d = pop ? rdata : rec_q;
    cnt_d = cnt_q + 32'(state_q == PULSE);
    state_d = pop ? SETUP : (state_q == SETUP) ? PULSE : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_q <= 1'b0;
      rec_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      rec_q <= rec_d;
      cnt_q <= cnt_d;
    end
  end
  assign valid_o = state_q == PULSE;
  assign pc_o = rec_q[PC_MSB:PC_LSB];
  assign instr_o = rec_q[INSTR_MSB:INSTR_LSB];
  assign reg_addr_o = rec_q[RADDR_MSB:RADDR_LSB];
  assign reg_data_o = rec_q[RDATA_MSB:RDATA_LSB];
  assign is_load_o = rec_q[LOAD_BIT];
  assign is_store_o = rec_q[STORE_BIT];
  assign is_float_o = rec_q[FLOAT_BIT];
  assign mem_addr_o = rec_q[MADDR_MSB:MADDR_LSB];
  assign mem_data_o = rec_q[MDATA_MSB:MDATA_LSB];
  assign emit_cnt_o = cnt_q;
endmodule
